// File: rtl/sram_bus_bridge_pkg.sv
// Shared constants for the AVR<->SRAM bridge: FSM state encodings and wait counter width.
package sram_bus_pkg;

    localparam int WAIT_CNT_W = 4;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_SETUP = 3'd1;
    localparam logic [2:0] RD_WAIT  = 3'd2;
    localparam logic [2:0] RD_LATCH = 3'd3;
    localparam logic [2:0] WR_SETUP = 3'd4;
    localparam logic [2:0] WR_PULSE = 3'd5;
    localparam logic [2:0] WR_HOLD  = 3'd6;

endpackage

// File: rtl/sram_bus_bridge_if.sv
// Bridge bus bundle: master is the AVR + SRAM side (pins), slave is the bridge core.
interface sram_bus_bridge_if #(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 8
);
    logic                  avr_sreg_en;
    logic                  avr_si;
    logic                  avr_oe;
    logic                  avr_we;
    logic                  avr_counter;
    logic [DATA_WIDTH-1:0] avr_data_i;
    logic [DATA_WIDTH-1:0] avr_data_o;
    logic                  avr_data_oe;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_data_i;
    logic [DATA_WIDTH-1:0] sram_data_o;
    logic                  sram_data_oe;
    logic                  sram_ce_n;
    logic                  sram_oe_n;
    logic                  sram_we_n;
    logic                  busy;
    logic                  done;

    modport master (
        output avr_sreg_en, avr_si, avr_oe, avr_we, avr_counter, avr_data_i, sram_data_i,
        input  avr_data_o, avr_data_oe, sram_addr, sram_data_o, sram_data_oe,
               sram_ce_n, sram_oe_n, sram_we_n, busy, done
    );

    modport slave (
        input  avr_sreg_en, avr_si, avr_oe, avr_we, avr_counter, avr_data_i, sram_data_i,
        output avr_data_o, avr_data_oe, sram_addr, sram_data_o, sram_data_oe,
               sram_ce_n, sram_oe_n, sram_we_n, busy, done
    );

endinterface

// File: rtl/sram_bus_bridge_addr_sreg.sv
// SRAM address register: MSB-first serial load, +1 increment with natural wrap to zero.
module addr_sreg #(
    parameter int ADDR_WIDTH = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  shift_en,
    input  logic                  si,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] addr
);

    // Shift takes priority; the caller only raises inc when no shift is happening.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
        end else if (shift_en) begin
            addr <= {addr[ADDR_WIDTH-2:0], si};
        end else if (inc) begin
            addr <= addr + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/sram_bus_bridge.sv
// AVR<->SRAM bridge: serial address load, strobe-triggered SRAM read/write FSM with wait states.
module sram_bus_bridge
    import sram_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 21,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 1,
    parameter int AUTO_INC    = 1
) (
    input  logic             clk,
    input  logic             reset,
    sram_bus_bridge_if.slave bus
);

    localparam logic [WAIT_CNT_W-1:0] WS_CNT  = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] WS_LAST = WAIT_CNT_W'(WAIT_STATES - 1);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE = WAIT_CNT_W'(1);

    logic [2:0]            state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  oe_q, we_q, cnt_q;
    logic                  oe_edge, we_edge, cnt_edge;
    logic                  ce_n, oe_n, we_n, sram_oe;
    logic                  rd_valid, done_q, cnt_pending;
    logic [DATA_WIDTH-1:0] avr_data_q, sram_data_q;
    logic                  idle, shift_en, inc_idle, inc_auto;

    assign oe_edge  = oe_q  & ~bus.avr_oe;
    assign we_edge  = we_q  & ~bus.avr_we;
    assign cnt_edge = cnt_q & ~bus.avr_counter;

    assign idle     = (state == IDLE);
    assign shift_en = idle & ~bus.avr_sreg_en;
    assign inc_idle = idle & ~shift_en & (cnt_pending | cnt_edge);
    assign inc_auto = (AUTO_INC != 0) && (state == RD_LATCH || state == WR_HOLD);

    addr_sreg #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .si       (bus.avr_si),
        .inc      (inc_idle | inc_auto),
        .addr     (bus.sram_addr)
    );

    // Counter edges seen mid-access are remembered once and applied in the first idle cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_pending <= 1'b0;
        end else if (!idle) begin
            if (cnt_edge) cnt_pending <= 1'b1;
        end else if (inc_idle) begin
            cnt_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            oe_q        <= 1'b1;
            we_q        <= 1'b1;
            cnt_q       <= 1'b1;
            ce_n        <= 1'b1;
            oe_n        <= 1'b1;
            we_n        <= 1'b1;
            sram_oe     <= 1'b0;
            rd_valid    <= 1'b0;
            done_q      <= 1'b0;
            avr_data_q  <= '0;
            sram_data_q <= '0;
        end else begin
            oe_q   <= bus.avr_oe;
            we_q   <= bus.avr_we;
            cnt_q  <= bus.avr_counter;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (oe_edge) begin
                        state    <= RD_SETUP;
                        ce_n     <= 1'b0;
                        oe_n     <= 1'b0;
                        rd_valid <= 1'b0;
                    end else if (we_edge) begin
                        state       <= WR_SETUP;
                        sram_data_q <= bus.avr_data_i;
                        ce_n        <= 1'b0;
                        sram_oe     <= 1'b1;
                    end
                end
                RD_SETUP: begin
                    if (WAIT_STATES == 0) begin
                        state <= RD_LATCH;
                    end else begin
                        wait_cnt <= WS_LAST;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == '0) state <= RD_LATCH;
                    else                wait_cnt <= wait_cnt - CNT_ONE;
                end
                RD_LATCH: begin
                    avr_data_q <= bus.sram_data_i;
                    rd_valid   <= 1'b1;
                    ce_n       <= 1'b1;
                    oe_n       <= 1'b1;
                    done_q     <= 1'b1;
                    state      <= IDLE;
                end
                WR_SETUP: begin
                    we_n     <= 1'b0;
                    wait_cnt <= WS_CNT;
                    state    <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (wait_cnt == '0) begin
                        we_n  <= 1'b1;
                        state <= WR_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_ONE;
                    end
                end
                WR_HOLD: begin
                    ce_n    <= 1'b1;
                    sram_oe <= 1'b0;
                    done_q  <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.avr_data_o   = avr_data_q;
    assign bus.avr_data_oe  = rd_valid & ~bus.avr_oe;
    assign bus.sram_data_o  = sram_data_q;
    assign bus.sram_data_oe = sram_oe;
    assign bus.sram_ce_n    = ce_n;
    assign bus.sram_oe_n    = oe_n;
    assign bus.sram_we_n    = we_n;
    assign bus.busy         = ~idle;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Scoreboard bench for sram_bus_bridge: expected accesses queued at strobe, checked at done.
module tb_sram_bus_bridge;

    localparam int AW = 21;
    localparam int DW = 8;
    localparam int WS = 1;

    typedef struct {
        bit            rd;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    sram_bus_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_bus_bridge #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .WAIT_STATES (WS),
        .AUTO_INC    (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t          sb[$];
    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    int unsigned   we_viol  = 0;
    logic [AW-1:0] model_addr;
    int unsigned   we_low, we_rise, oe_fall, ce_bad, lat;
    int unsigned   inj_cnt_at = 0;
    int unsigned   inj_we_at  = 0;

    // write strobe must never be active without the data bus being driven
    always @(negedge clk)
        if (bus.sram_we_n == 1'b0 && bus.sram_data_oe == 1'b0) we_viol++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_addr(input logic [AW-1:0] v);
        int unsigned strobes = 0;
        for (int i = AW - 1; i >= 0; i--) begin
            bus.avr_sreg_en = 1'b0;
            bus.avr_si      = v[i];
            tick();
            if (bus.sram_ce_n == 1'b0 || bus.sram_we_n == 1'b0) strobes++;
        end
        bus.avr_sreg_en = 1'b1;
        model_addr = v;
        check_eq("shift_addr", 32'(bus.sram_addr), 32'(v));
        check_eq("shift_no_strobe", strobes, 0);
    endtask

    task automatic pulse_counter();
        bus.avr_counter = 1'b0;
        tick();
        bus.avr_counter = 1'b1;
        tick();
    endtask

    task automatic release_strobes();
        bus.avr_oe = 1'b1;
        bus.avr_we = 1'b1;
    endtask

    task automatic run_access(input bit rd, input logic [DW-1:0] d);
        exp_t e, got_e;
        bit prev_we = 1'b1;
        bit prev_oe = 1'b0;
        e.rd = rd;
        e.data = d;
        e.addr = model_addr + AW'(1);
        sb.push_back(e);
        if (rd) begin
            bus.sram_data_i = d;
            bus.avr_oe      = 1'b0;
        end else begin
            bus.avr_data_i = d;
            bus.avr_we     = 1'b0;
        end
        lat = 0; we_low = 0; we_rise = 0; oe_fall = 0; ce_bad = 0;
        for (int unsigned k = 1; k <= 32; k++) begin
            tick();
            bus.avr_counter = (k == inj_cnt_at) ? 1'b0 : 1'b1;
            if (k == inj_we_at) bus.avr_we = 1'b0;
            if (!bus.sram_we_n) we_low++;
            if (!bus.sram_we_n && bus.sram_ce_n) ce_bad++;
            if (!prev_we && bus.sram_we_n && we_rise == 0) we_rise = k;
            if (prev_oe && !bus.sram_data_oe && oe_fall == 0) oe_fall = k;
            prev_we = bus.sram_we_n;
            prev_oe = bus.sram_data_oe;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        bus.avr_counter = 1'b1;
        got_e = sb.pop_front();
        if (lat == 0) begin
            check_eq("done_timeout", 0, 1);
        end else begin
            if (got_e.rd) check_eq("rd_data", 32'(bus.avr_data_o), 32'(got_e.data));
            else          check_eq("wr_data", 32'(bus.sram_data_o), 32'(got_e.data));
            check_eq("addr_after", 32'(bus.sram_addr), 32'(got_e.addr));
        end
        model_addr = got_e.addr;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.avr_sreg_en = 1'b1;
        bus.avr_si      = 1'b0;
        bus.avr_oe      = 1'b1;
        bus.avr_we      = 1'b1;
        bus.avr_counter = 1'b1;
        bus.avr_data_i  = '0;
        bus.sram_data_i = '0;
        model_addr      = '0;
        tick();
        check_eq("reset_ctrl",
                 {25'd0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_data_oe,
                  bus.avr_data_oe, bus.busy, bus.done}, 32'b1110000);
        check_eq("reset_addr", 32'(bus.sram_addr), 0);
        check_eq("reset_data", {16'd0, bus.avr_data_o, bus.sram_data_o}, 0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check_eq("idle_no_spurious", {30'd0, bus.busy, bus.done}, 0);

        shift_addr(21'h1CCCCF);

        // read 0xAA: data and done 3 clks after the oe edge clock
        run_access(1'b1, 8'hAA);
        check_eq("rd_latency", lat, 3 + WS);
        check_eq("rd_avr_oe", 32'(bus.avr_data_oe), 1);
        bus.sram_data_i = 8'h55;
        tick();
        check_eq("done_one_clk", 32'(bus.done), 0);
        check_eq("rd_data_held", 32'(bus.avr_data_o), 32'h0AA);
        release_strobes();
        #1;
        check_eq("rd_avr_oe_off", 32'(bus.avr_data_oe), 0);
        tick();

        // write 0xEE
        run_access(1'b0, 8'hEE);
        check_eq("wr_latency", lat, 4 + WS);
        check_eq("wr_we_low", we_low, WS + 1);
        check_eq("wr_we_in_ce", ce_bad, 0);
        check_eq("wr_oe_after_we", oe_fall - we_rise, 1);
        release_strobes();
        tick();

        // another read / write pattern
        run_access(1'b1, 8'h3C);
        release_strobes();
        tick();
        run_access(1'b0, 8'h81);
        release_strobes();
        tick();

        // counter wrap
        shift_addr(21'h1FFFFF);
        pulse_counter();
        check_eq("counter_wrap", 32'(bus.sram_addr), 0);
        model_addr = '0;

        // counter edge during read: +1 at done, +1 queued
        shift_addr(21'h000100);
        inj_cnt_at = 2;
        run_access(1'b1, 8'h5A);
        inj_cnt_at = 0;
        tick();
        check_eq("counter_queued", 32'(bus.sram_addr), 32'h102);
        model_addr = 21'h000102;
        release_strobes();
        tick();

        // oe and we edges together: read only
        bus.avr_we = 1'b0;
        run_access(1'b1, 8'hC3);
        check_eq("simul_no_we", we_low, 0);
        tick();
        tick();
        check_eq("simul_write_dropped", 32'(bus.busy), 0);
        release_strobes();
        tick();

        // we edge mid-read ignored
        inj_we_at = 2;
        run_access(1'b1, 8'h96);
        inj_we_at = 0;
        check_eq("midread_no_we", we_low, 0);
        tick();
        tick();
        check_eq("midread_write_dropped", 32'(bus.busy), 0);
        release_strobes();
        tick();

        // reset during WR_PULSE
        bus.avr_data_i = 8'h77;
        bus.avr_we     = 1'b0;
        for (int unsigned k = 0; k < 10 && bus.sram_we_n; k++) tick();
        check_eq("wr_pulse_reached", 32'(bus.sram_we_n), 0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_mid_ctrl",
                 {28'd0, bus.sram_we_n, bus.sram_ce_n, bus.sram_data_oe, bus.busy}, 32'b1100);
        check_eq("rst_mid_addr", 32'(bus.sram_addr), 0);
        bus.avr_we = 1'b1;
        tick();
        reset = 1'b0;
        model_addr = '0;
        tick();
        tick();
        check_eq("rst_no_done", {30'd0, bus.busy, bus.done}, 0);

        run_access(1'b1, 8'h42);
        release_strobes();
        tick();

        check_eq("sb_empty", sb.size(), 0);
        check_eq("we_without_oe", we_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
